noc_pkt_dec: RTL and testbench
==============================

Name: noc_pkt_dec

Overview:
- Receive-side decoder for the XY-NoC bus; one instance per PE.
- Snoops <row, col, data> packets placed on the shared bus by the encoder and accepts only those whose row/col match its own ID. Strips the header and buffers the payload in a small FIFO for the PE.
- Counts accepted packets against a configured total and signals completion once all of them have been delivered to the PE.

Parameters:
- DATA_WIDTH, 16, element width; payload is 2*DATA_WIDTH bits.
- NUM_ROW, 4, PE rows; ROW_W = max(1, clog2(NUM_ROW)).
- NUM_COL, 4, PE columns; COL_W = max(1, clog2(NUM_COL)).
- FIFO_DEPTH, 4, payload buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  one-cycle start pulse; honoured only in IDLE.
- cfg_row_id  in  ROW_W  this PE's row, latched on an honoured cfg_start.
- cfg_col_id  in  COL_W  this PE's column, latched on an honoured cfg_start.
- cfg_num_pkt  in  16  packets expected this job, latched on an honoured cfg_start.
- in_valid  in  1  bus packet valid.
- in_row  in  ROW_W  packet destination row.
- in_col  in  COL_W  packet destination column.
- in_data  in  2*DATA_WIDTH  packet payload.
- in_ready  out  1  this decoder's bus ready; the bus controller ANDs all decoders' in_ready.
- out_valid  out  1  payload available to the PE.
- out_data  out  2*DATA_WIDTH  payload at the FIFO head.
- out_ready  in  1  PE accepts the payload.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job completion.
- err_unexp  out  1  sticky; a matching packet arrived outside ACTIVE.

Behaviour:
- Reset (async on rstn low): state=IDLE; FIFO empty with pointers 0; pkt_cnt=0; latched IDs and count=0; out_valid=0, out_data=0, done=0, err_unexp=0, busy=0.
- Match: match = in_valid && in_row==row_id && in_col==col_id, compared combinationally against the latched IDs.
- in_ready (combinational):
  - in ACTIVE: !match || !full;
  - in all other states: 1.
  - A non-matching packet never stalls the bus.
- Accept: in ACTIVE, match && !full pushes in_data; pkt_cnt increments.
- State machine:
  - IDLE: on cfg_start, latch the config, clear pkt_cnt and err_unexp, then go to ACTIVE. If cfg_num_pkt==0, go directly to DRAIN.
  - ACTIVE: when an accept occurs with pkt_cnt==num_pkt-1, go to DRAIN.
  - DRAIN: no pushes. When the FIFO is empty (including an empty result after a same-cycle pop), assert done for 1 cycle and go to IDLE.
  - cfg_start outside IDLE is ignored and does not alter the latched config.
- Unexpected packets: in IDLE or DRAIN, a match (against the latched IDs) is consumed and dropped and err_unexp is set. err_unexp clears only on an honoured cfg_start or on reset.
- FIFO behaviour:
  - Show-ahead: out_valid = !empty; out_data = mem[rd_ptr].
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed whenever !full; occupancy is unchanged.
  - When full, in_ready depends only on the registered full flag; a same-cycle pop does not free a slot for a push.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a packet accepted at edge N is presented with out_valid=1 after edge N (1 cycle). Data order is preserved.
- Reset mid-job aborts immediately with no done pulse; FIFO contents are discarded.
- Widths: pkt_cnt and num_pkt are 16 bits; 0xFFFF is a legal count.

Decomposition:
- Shared package noc_pkg holds:
  - the ROW_W/COL_W helper functions;
  - typedef noc_pkt_t = struct {row, col, data}, shared with the encoder;
  - typedef dec_state_t = {IDLE, ACTIVE, DRAIN}.
- Sub-module noc_fifo: a parameterised synchronous show-ahead FIFO with full/empty flags. The decoder instantiates it and keeps match, count and FSM logic at top level.

Test Plan:
- ID (1,2), num_pkt=3:
  - stimulus: send (1,2,A), (0,2,X), (1,2,B), (1,2,C) with out_ready=1;
  - response: out_data A,B,C, each one cycle after its accept; X is dropped with in_ready=1; done pulses once; busy falls; err_unexp=0.
- FIFO_DEPTH=4, out_ready=0:
  - stimulus: 6 matching packets;
  - response: 4 accepted, then in_ready=0; a non-matching packet during the stall still sees in_ready=1; raising out_ready drains in order and the remaining 2 are accepted.
- Full FIFO:
  - stimulus: out_ready=1 and a matching in_valid in the same cycle;
  - response: the pop occurs and the push does not; the next cycle accepts the push.
- num_pkt=0:
  - stimulus: cfg_start;
  - response: IDLE→DRAIN→done pulse 2 cycles after the start edge; no packets are accepted.
- Unexpected packet:
  - stimulus: in IDLE after a job with ID (3,3), a packet to (3,3);
  - response: in_ready=1, nothing is pushed, err_unexp=1; the next cfg_start clears it.
- Reset mid-job:
  - stimulus: assert rstn=0 asynchronously mid-job with 2 entries buffered;
  - response: out_valid=0, busy=0 immediately; no done pulse.

Source files
------------

// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Shared XY-NoC definitions: ID width helpers, the bus packet
//               layout shared with the encoder, and the decoder state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    // Row/column ID width: clog2 of the dimension, never narrower than 1 bit
    function automatic int noc_row_w(input int num_row);
        return (num_row <= 1) ? 1 : $clog2(num_row);
    endfunction

    function automatic int noc_col_w(input int num_col);
        return (num_col <= 1) ? 1 : $clog2(num_col);
    endfunction

    // Default bus geometry used by the shared packet layout
    localparam int c_NOC_DATA_W = 16;
    localparam int c_NOC_ROW_W  = noc_row_w(4);
    localparam int c_NOC_COL_W  = noc_col_w(4);

    // Packet as it appears on the shared bus: destination header plus payload
    typedef struct packed {
        logic [c_NOC_ROW_W-1:0]    row;
        logic [c_NOC_COL_W-1:0]    col;
        logic [2*c_NOC_DATA_W-1:0] data;
    } noc_pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/noc_fifo.sv
// ============================================================================
// Module      : noc_fifo
// Description : Synchronous show-ahead FIFO with full/empty flags and an
//               occupancy count. Head entry is visible on pop_data at all times.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == c_FULL_CNT);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; memory is cleared so the head reads zero after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_pkt_dec.sv
// ============================================================================
// Module      : noc_pkt_dec
// Description : XY-NoC receive-side decoder. Accepts bus packets addressed to
//               this PE's latched row/col, buffers payloads for the PE, counts
//               them against the job total and pulses done once all drained.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_pkt_dec
    import noc_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_ROW    = 4,
    parameter  int NUM_COL    = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int ROW_W      = noc_row_w(NUM_ROW),
    localparam int COL_W      = noc_col_w(NUM_COL)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_start,
    input  logic [ROW_W-1:0]        cfg_row_id,
    input  logic [COL_W-1:0]        cfg_col_id,
    input  logic [15:0]             cfg_num_pkt,
    input  logic                    in_valid,
    input  logic [ROW_W-1:0]        in_row,
    input  logic [COL_W-1:0]        in_col,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err_unexp
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] c_ONE_ENTRY = CW'(1);

    dec_state_t r_state;
    dec_state_t w_state_nxt;

    logic [ROW_W-1:0] r_row_id;
    logic [COL_W-1:0] r_col_id;
    logic [15:0]      r_num_pkt;
    logic [15:0]      r_pkt_cnt;
    logic             r_err_unexp;
    logic             r_done;

    logic             w_match;
    logic             w_start;
    logic             w_accept;
    logic             w_unexp;
    logic             w_pop;
    logic             w_drain_empty;
    logic             w_done_nxt;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;

    assign w_match  = in_valid && (in_row == r_row_id) && (in_col == r_col_id);
    assign w_start  = (r_state == IDLE) && cfg_start;
    assign w_accept = (r_state == ACTIVE) && w_match && !w_fifo_full;
    // Outside ACTIVE a matching packet is swallowed so the shared bus never stalls
    assign w_unexp  = (r_state != ACTIVE) && w_match;
    assign w_pop    = !w_fifo_empty && out_ready;
    // No pushes happen in DRAIN, so a pop of the last entry empties the buffer
    assign w_drain_empty = w_fifo_empty || ((w_fifo_count == c_ONE_ENTRY) && w_pop);

    assign in_ready  = (r_state == ACTIVE) ? (!w_match || !w_fifo_full) : 1'b1;
    assign out_valid = !w_fifo_empty;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err_unexp = r_err_unexp;

    noc_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_accept),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (out_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Next-state and completion-pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = (cfg_num_pkt == 16'd0) ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_accept && (r_pkt_cnt == r_num_pkt - 16'd1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_empty) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Job configuration, packet counter and sticky unexpected-packet flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row_id    <= '0;
            r_col_id    <= '0;
            r_num_pkt   <= '0;
            r_pkt_cnt   <= '0;
            r_err_unexp <= 1'b0;
        end else begin
            if (w_start) begin
                r_row_id  <= cfg_row_id;
                r_col_id  <= cfg_col_id;
                r_num_pkt <= cfg_num_pkt;
                r_pkt_cnt <= '0;
            end else if (w_accept) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_start) begin
                r_err_unexp <= 1'b0;
            end else if (w_unexp) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_noc_pkt_dec.sv
// ============================================================================
// Module      : tb_noc_pkt_dec
// Description : Self-checking bench for noc_pkt_dec using per-cycle vector
//               records plus a hand-written asynchronous reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_pkt_dec;

    logic        clk;
    logic        rstn;
    logic        cfg_start;
    logic [1:0]  cfg_row_id;
    logic [1:0]  cfg_col_id;
    logic [15:0] cfg_num_pkt;
    logic        in_valid;
    logic [1:0]  in_row;
    logic [1:0]  in_col;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err_unexp;

    int n_tests = 0;
    int n_fail  = 0;

    noc_pkt_dec #(
        .DATA_WIDTH (16),
        .NUM_ROW    (4),
        .NUM_COL    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_start   (cfg_start),
        .cfg_row_id  (cfg_row_id),
        .cfg_col_id  (cfg_col_id),
        .cfg_num_pkt (cfg_num_pkt),
        .in_valid    (in_valid),
        .in_row      (in_row),
        .in_col      (in_col),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .err_unexp   (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs held for the cycle, outputs expected during that cycle
    typedef struct {
        logic        start;
        logic [1:0]  crow;
        logic [1:0]  ccol;
        logic [15:0] cnum;
        logic        iv;
        logic [1:0]  r;
        logic [1:0]  c;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic start, input logic [1:0] crow, input logic [1:0] ccol, input logic [15:0] cnum,
        input logic iv, input logic [1:0] r, input logic [1:0] c, input logic [31:0] d, input logic ordy,
        input logic e_ir, input logic e_ov, input logic [31:0] e_od,
        input logic e_busy, input logic e_done, input logic e_err);
        vec_t v;
        v.start = start; v.crow = crow; v.ccol = ccol; v.cnum = cnum;
        v.iv = iv; v.r = r; v.c = c; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
        v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @vec %0d: got %h want %h", nm, idx, got, want);
        end
    endtask

    localparam logic [31:0] A  = 32'hAAAA_0001;
    localparam logic [31:0] B  = 32'hBBBB_0002;
    localparam logic [31:0] C  = 32'hCCCC_0003;
    localparam logic [31:0] X  = 32'h0BAD_0BAD;
    localparam logic [31:0] D1 = 32'hD1D1_0001;
    localparam logic [31:0] Z  = 32'h2222_ZZ00 & 32'hFFFF_FF00;
    localparam logic [31:0] E1 = 32'hE1E1_0001;
    localparam logic [31:0] E2 = 32'hE2E2_0002;

    function automatic logic [31:0] p(input int k);
        return 32'h5000_0000 + 32'(k);
    endfunction

    initial begin
        rstn = 1'b0; cfg_start = 1'b0; cfg_row_id = '0; cfg_col_id = '0; cfg_num_pkt = '0;
        in_valid = 1'b0; in_row = '0; in_col = '0; in_data = '0; out_ready = 1'b0;

        // Basic job: ID (1,2), 3 packets, one stray packet to (0,2)
        vecs.push_back(mk(1,1,2,3,  0,0,0,0,    1,  1,0,0,    0,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,A,    1,  1,0,0,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,0,2,X,    1,  1,1,A,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,B,    1,  1,0,0,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,C,    1,  1,1,B,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,1,C,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    0,0,0));
        // Back-pressure: 6 packets, PE stalled; ignored cfg_start mid-job; full-pop corner
        vecs.push_back(mk(1,1,2,6,  0,0,0,0,    0,  1,0,0,    0,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(0), 0,  1,0,0,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(1), 0,  1,1,p(0), 1,0,0));
        vecs.push_back(mk(1,0,0,1,  1,1,2,p(2), 0,  1,1,p(0), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(3), 0,  1,1,p(0), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(4), 0,  0,1,p(0), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,2,2,X,    0,  1,1,p(0), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(4), 1,  0,1,p(0), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(4), 1,  1,1,p(1), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,1,2,p(5), 1,  1,1,p(2), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,1,p(3), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,1,p(4), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,1,p(5), 1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    0,0,0));
        // Zero-packet job: straight to DRAIN, done two cycles after start edge
        vecs.push_back(mk(1,1,2,0,  0,0,0,0,    1,  1,0,0,    0,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,0,0,    0,0,0));
        // One-packet job at (3,3), then an unexpected packet in IDLE
        vecs.push_back(mk(1,3,3,1,  0,0,0,0,    0,  1,0,0,    0,0,0));
        vecs.push_back(mk(0,0,0,0,  1,3,3,D1,   0,  1,0,0,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    1,  1,1,D1,   1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    0,  1,0,0,    0,1,0));
        vecs.push_back(mk(0,0,0,0,  1,3,3,Z,    0,  1,0,0,    0,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    0,  1,0,0,    0,0,1));
        vecs.push_back(mk(1,3,3,5,  0,0,0,0,    0,  1,0,0,    0,0,1));
        vecs.push_back(mk(0,0,0,0,  1,3,3,E1,   0,  1,0,0,    1,0,0));
        vecs.push_back(mk(0,0,0,0,  1,3,3,E2,   0,  1,1,E1,   1,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0,    0,  1,1,E1,   1,0,0));

        // Reset state while rstn is held low
        #2;
        chk("rst_out_valid", -1, 32'(out_valid), 32'd0);
        chk("rst_out_data",  -1, out_data,       32'd0);
        chk("rst_busy",      -1, 32'(busy),      32'd0);
        chk("rst_done",      -1, 32'(done),      32'd0);
        chk("rst_err_unexp", -1, 32'(err_unexp), 32'd0);
        chk("rst_in_ready",  -1, 32'(in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cfg_start   = vecs[i].start;
            cfg_row_id  = vecs[i].crow;
            cfg_col_id  = vecs[i].ccol;
            cfg_num_pkt = vecs[i].cnum;
            in_valid    = vecs[i].iv;
            in_row      = vecs[i].r;
            in_col      = vecs[i].c;
            in_data     = vecs[i].d;
            out_ready   = vecs[i].ordy;
            @(negedge clk);
            chk("in_ready",  i, 32'(in_ready),  32'(vecs[i].e_ir));
            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) chk("out_data", i, out_data, vecs[i].e_od);
            chk("busy",      i, 32'(busy),      32'(vecs[i].e_busy));
            chk("done",      i, 32'(done),      32'(vecs[i].e_done));
            chk("err_unexp", i, 32'(err_unexp), 32'(vecs[i].e_err));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-job with two payloads buffered
        cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", -2, 32'(out_valid), 32'd0);
        chk("arst_busy",      -2, 32'(busy),      32'd0);
        chk("arst_done",      -2, 32'(done),      32'd0);
        chk("arst_err_unexp", -2, 32'(err_unexp), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done",      -3 - k, 32'(done),      32'd0);
            chk("post_rst_out_valid", -3 - k, 32'(out_valid), 32'd0);
            chk("post_rst_busy",      -3 - k, 32'(busy),      32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
